// File: rtl/adpll_phase_detector.sv
// Counter-based phase/frequency detector: measures the clk-cycle gap between
// synchronized rising edges of ref_in and fb_in, reports a signed error and tracks lock.
module adpll_phase_detector #(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned LOCK_TOL = 1,
    parameter int unsigned LOCK_CNT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       ref_in,
    input  logic       fb_in,
    output logic       err_sign,
    output logic [4:0] err_mag,
    output logic       err_valid,
    output logic       lock
);

    localparam int unsigned LOCK_W  = $clog2(LOCK_CNT + 1);
    localparam int unsigned MAG_MAX = 31;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT     = 3'd1;
    localparam logic [2:0] S_REF_LEAD = 3'd2;
    localparam logic [2:0] S_FB_LEAD  = 3'd3;
    localparam logic [2:0] S_REPORT   = 3'd4;

    logic [1:0]        ref_sync, fb_sync;
    logic              ref_prev, fb_prev;
    logic              ref_pulse_c, fb_pulse_c;
    logic [2:0]        state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [LOCK_W-1:0] lock_cnt, lock_cnt_nx;
    logic              report_c;
    logic              rep_sign_c;
    logic [4:0]        rep_mag_c;

    function automatic logic [4:0] sat_mag(input logic [CNT_W-1:0] c);
        if (32'(c) > MAG_MAX) return 5'(MAG_MAX);
        return 5'(c);
    endfunction

    // Two-flop synchronizers plus previous-value flops for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ref_sync <= 2'b00;
            fb_sync  <= 2'b00;
            ref_prev <= 1'b0;
            fb_prev  <= 1'b0;
        end else begin
            ref_sync <= {ref_sync[0], ref_in};
            fb_sync  <= {fb_sync[0], fb_in};
            ref_prev <= ref_sync[1];
            fb_prev  <= fb_sync[1];
        end
    end

    assign ref_pulse_c = ref_sync[1] & ~ref_prev;
    assign fb_pulse_c  = fb_sync[1] & ~fb_prev;

    // State and gap counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state, counter and report decode
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        report_c    = 1'b0;
        rep_sign_c  = err_sign;
        rep_mag_c   = err_mag;
        lock_cnt_nx = lock_cnt;
        if (!enable) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE: state_nx = S_WAIT;
                S_WAIT: begin
                    if (ref_pulse_c && fb_pulse_c) begin
                        report_c   = 1'b1;
                        rep_sign_c = 1'b0;
                        rep_mag_c  = 5'd0;
                    end else if (ref_pulse_c) begin
                        state_nx = S_REF_LEAD;
                        cnt_nx   = CNT_W'(1);
                    end else if (fb_pulse_c) begin
                        state_nx = S_FB_LEAD;
                        cnt_nx   = CNT_W'(1);
                    end
                end
                S_REF_LEAD, S_FB_LEAD: begin
                    cnt_nx = cnt + CNT_W'(1);
                    if ((state == S_REF_LEAD) ? fb_pulse_c : ref_pulse_c) begin
                        report_c   = 1'b1;
                        rep_sign_c = (state == S_FB_LEAD);
                        rep_mag_c  = sat_mag(cnt);
                    end else if (cnt == CNT_W'(TIMEOUT)) begin
                        report_c   = 1'b1;
                        rep_sign_c = (state == S_FB_LEAD);
                        rep_mag_c  = 5'(MAG_MAX);
                    end
                end
                S_REPORT: state_nx = S_WAIT;
                default:  state_nx = S_IDLE;
            endcase
            if (report_c) begin
                state_nx = S_REPORT;
                if (32'(rep_mag_c) <= LOCK_TOL)
                    lock_cnt_nx = (lock_cnt == LOCK_W'(LOCK_CNT)) ? lock_cnt
                                                                  : lock_cnt + LOCK_W'(1);
                else
                    lock_cnt_nx = '0;
            end
        end
        if (!enable) lock_cnt_nx = '0;
    end

    // Registered report outputs; sign/magnitude hold between reports
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_sign  <= 1'b0;
            err_mag   <= 5'd0;
            err_valid <= 1'b0;
            lock      <= 1'b0;
            lock_cnt  <= '0;
        end else begin
            err_valid <= report_c;
            lock_cnt  <= lock_cnt_nx;
            lock      <= (lock_cnt_nx == LOCK_W'(LOCK_CNT));
            if (report_c) begin
                err_sign <= rep_sign_c;
                err_mag  <= rep_mag_c;
            end
        end
    end

endmodule

// File: tb/tb_adpll_phase_detector.sv
// Scoreboard bench for adpll_phase_detector: stimulus schedules input rises,
// a model predicts each report (cycle, sign, magnitude, lock), a monitor checks them.
module tb_adpll_phase_detector;

    localparam int TIMEOUT  = 255;
    localparam int LOCK_TOL = 1;
    localparam int LOCK_CNT = 8;

    logic       clk = 1'b0;
    logic       reset, enable, ref_in, fb_in;
    logic       err_sign, err_valid, lock;
    logic [4:0] err_mag;

    typedef struct {
        int cyc;
        int sign;
        int mag;
        int lk;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   lock_run = 0;
    int   last_mag = 0;
    bit   prev_v = 1'b0;

    adpll_phase_detector #(
        .CNT_W(8), .TIMEOUT(TIMEOUT), .LOCK_TOL(LOCK_TOL), .LOCK_CNT(LOCK_CNT)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .ref_in(ref_in), .fb_in(fb_in),
        .err_sign(err_sign), .err_mag(err_mag), .err_valid(err_valid), .lock(lock)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a report lands two sampling edges after the lagging rise is sampled
    task automatic push_exp(input int c, input int s, input int m);
        exp_t e;
        if (m <= LOCK_TOL) lock_run = (lock_run < LOCK_CNT) ? lock_run + 1 : LOCK_CNT;
        else               lock_run = 0;
        e.cyc = c; e.sign = s; e.mag = m; e.lk = (lock_run == LOCK_CNT) ? 1 : 0;
        last_mag = m;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        for (int k = 0; k < 600 && exp_q.size() > 0; k++) @(negedge clk);
        if (exp_q.size() > 0) begin
            chk("report_timeout", 0, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Raise ref at step dr and fb at step df (-1 = never); sampling edge = cyc+1
    task automatic meas(input int dr, input int df);
        int ra, fa, last, n;
        ra = -1; fa = -1;
        last = (dr > df) ? dr : df;
        for (int j = 0; j <= last; j++) begin
            @(negedge clk);
            if (j == dr) begin ref_in = 1'b1; ra = cyc + 1; end
            if (j == df) begin fb_in  = 1'b1; fa = cyc + 1; end
        end
        if (fa < 0)        push_exp(ra + TIMEOUT + 2, 0, 31);
        else if (ra < 0)   push_exp(fa + TIMEOUT + 2, 1, 31);
        else if (ra == fa) push_exp(ra + 2, 0, 0);
        else begin
            n = (fa > ra) ? fa - ra : ra - fa;
            push_exp(((fa > ra) ? fa : ra) + 2, (fa < ra) ? 1 : 0, (n > 31) ? 31 : n);
        end
        drain();
        @(negedge clk);
        ref_in = 1'b0;
        fb_in  = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic meas_d(input int d);
        if (d >= 0) meas(0, d);
        else        meas(-d, 0);
    endtask

    // Monitor: compare every err_valid strobe against the head of the queue
    always @(negedge clk) begin
        if (reset) begin
            prev_v <= 1'b0;
        end else begin
            if (err_valid) begin
                if (prev_v) chk("valid_back_to_back", 1, 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("valid_cycle", cyc, e.cyc);
                    chk("err_sign", int'(err_sign), e.sign);
                    chk("err_mag", int'(err_mag), e.mag);
                    chk("lock_at_report", int'(lock), e.lk);
                end
            end
            prev_v <= err_valid;
        end
    end

    initial begin
        reset = 1'b1; enable = 1'b0; ref_in = 1'b0; fb_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_sign", int'(err_sign), 0);
        chk("reset_mag", int'(err_mag), 0);
        chk("reset_valid", int'(err_valid), 0);
        chk("reset_lock", int'(lock), 0);
        reset = 1'b0;
        enable = 1'b1;
        repeat (4) @(negedge clk);

        meas_d(5);        // ref leads by 5
        meas_d(-12);      // fb leads by 12
        meas_d(0);        // simultaneous
        meas_d(40);       // saturation
        meas(0, -1);      // ref timeout
        meas(-1, 0);      // fb timeout
        for (int i = 0; i < LOCK_CNT; i++) meas_d((i % 3 == 0) ? 0 : ((i % 2 == 0) ? 1 : -1));
        meas_d(3);        // breaks lock

        // Reset in the middle of a ref-led measurement
        @(negedge clk); ref_in = 1'b1;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midreset_sign", int'(err_sign), 0);
        chk("midreset_mag", int'(err_mag), 0);
        chk("midreset_valid", int'(err_valid), 0);
        chk("midreset_lock", int'(lock), 0);
        repeat (3) @(negedge clk);
        ref_in = 1'b0;
        reset = 1'b0;
        lock_run = 0; last_mag = 0;
        repeat (6) @(negedge clk);

        // Build lock, then drop enable in the middle of a count
        for (int i = 0; i < LOCK_CNT; i++) meas_d(1);
        chk("lock_built", int'(lock), 1);
        @(negedge clk); ref_in = 1'b1;
        repeat (5) @(negedge clk);
        enable = 1'b0;
        lock_run = 0;
        repeat (3) @(negedge clk);
        chk("disable_lock", int'(lock), 0);
        chk("disable_valid", int'(err_valid), 0);
        chk("disable_mag_hold", int'(err_mag), last_mag);
        repeat (20) @(negedge clk);
        ref_in = 1'b0;
        enable = 1'b1;
        repeat (4) @(negedge clk);

        // Randomized gaps, mostly within saturation range, occasionally a timeout
        for (int i = 0; i < 30; i++) begin
            int mode, d;
            mode = int'($urandom_range(0, 11));
            if (mode == 0) begin
                if ($urandom_range(0, 1) == 0) meas(0, -1);
                else                           meas(-1, 0);
            end else if (mode < 5) begin
                d = int'($urandom_range(0, 2)) - 1;
                meas_d(d);
            end else begin
                d = int'($urandom_range(0, 60));
                meas_d(($urandom_range(0, 1) == 0) ? d : -d);
            end
        end

        drain();
        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
